// File: rtl/piso_pkg.sv
// Shared types and width helpers for the parallel-in, serial-out transmitter.
package piso_pkg;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_e;

    // Default configuration and the counter widths it implies.
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_BIT_CYCLES  = 1;
    localparam int DEF_GAP_CYCLES  = 0;
    localparam int DEF_BIT_CNT_W   = $clog2(DEF_WIDTH);
    localparam int DEF_CYC_CNT_W   = $clog2(DEF_BIT_CYCLES) + 1;

    // Bit counter width: indexes bits 0..width-1 (width >= 2, so at least 1 bit).
    function automatic int bit_cnt_width(input int width);
        return $clog2(width);
    endfunction

    // Cycle counter width: counts 0..bit_cycles-1 inside one bit.
    function automatic int cyc_cnt_width(input int bit_cycles);
        return $clog2(bit_cycles) + 1;
    endfunction

    // Gap counter width: must hold the value gap_cycles itself.
    function automatic int gap_cnt_width(input int gap_cycles);
        return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
    endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Per-bit cycle counter: pulses bit_tick_o on the last cycle of every bit.
module piso_bit_timer #(
    parameter int BIT_CYCLES = 1,
    parameter int CW         = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_tick_o
);

    localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;

    assign bit_tick_o = en_i && (cyc_q == LAST_CYC);

    // Next count: hold, wrap at the end of a bit, or clear from the FSM.
    always_comb begin
        // NOTE: cyc_d gets a default before any branch so no latch is inferred.
        cyc_d = cyc_q;
        if (clear_i) begin
            cyc_d = '0;
        end else if (en_i) begin
            cyc_d = bit_tick_o ? '0 : cyc_q + 1'b1;
        end
    end

    // Cycle counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready accept, selectable bit
// order, per-bit stretching and an optional idle gap after each frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             dir,
    output logic             ready_out,
    output logic             sdata_out,
    output logic             frame_out,
    output logic             done_out
);

    localparam int BCW = bit_cnt_width(WIDTH);
    localparam int CCW = cyc_cnt_width(BIT_CYCLES);
    localparam int GCW = gap_cnt_width(GAP_CYCLES);

    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] LAST_GAP = GCW'(GAP_CYCLES);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             dir_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [GCW-1:0]   gap_cnt_q;
    logic             ready_q;
    logic             sdata_q;
    logic             frame_q;
    logic             done_q;
    logic             bit_tick;

    assign ready_out = ready_q;
    assign sdata_out = sdata_q;
    assign frame_out = frame_q;
    assign done_out  = done_q;

    // The timer runs only while shifting and restarts from zero for every frame.
    piso_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .CW         (CCW)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (state_q != SHIFT),
        .en_i       (state_q == SHIFT),
        .bit_tick_o (bit_tick)
    );

    // Shift toward the outgoing end chosen by the captured bit order.
    always_comb begin
        shreg_d = dir_q ? (shreg_q >> 1) : (shreg_q << 1);
    end

    // Transmit FSM; every output is registered so the first bit follows accept by one cycle.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses <= so every register samples pre-edge values.
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            dir_q     <= 1'b0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ready_q   <= 1'b1;
            sdata_q   <= 1'b0;
            frame_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in && ready_q) begin
                        shreg_q   <= data_in;
                        dir_q     <= dir;
                        bit_cnt_q <= '0;
                        sdata_q   <= dir ? data_in[0] : data_in[WIDTH-1];
                        frame_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_tick) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            shreg_q   <= '0;
                            sdata_q   <= 1'b0;
                            frame_q   <= 1'b0;
                            done_q    <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                ready_q <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                // The done cycle is already the first gap cycle.
                                gap_cnt_q <= GCW'(1);
                                state_q   <= GAP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shreg_q   <= shreg_d;
                            sdata_q   <= dir_q ? shreg_d[0] : shreg_d[WIDTH-1];
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == LAST_GAP) begin
                        gap_cnt_q <= '0;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer across three configurations:
//   A: WIDTH=8,  BIT_CYCLES=1, GAP_CYCLES=2
//   B: WIDTH=8,  BIT_CYCLES=3, GAP_CYCLES=0
//   C: WIDTH=32, BIT_CYCLES=1, GAP_CYCLES=0 (loopback into a serial-in register)
// Cycle c is the c-th cycle after the accept edge; sampling happens 1 time unit after each edge.
module tb_piso_serializer;

    logic clk;
    logic reset;

    logic [7:0]  a_data;
    logic        a_valid, a_dir, a_ready, a_sdata, a_frame, a_done;
    logic [7:0]  b_data;
    logic        b_valid, b_dir, b_ready, b_sdata, b_frame, b_done;
    logic [31:0] c_data;
    logic        c_valid, c_dir, c_ready, c_sdata, c_frame, c_done;

    logic [31:0] lb_q = '0;

    int checks   = 0;
    int failures = 0;

    piso_serializer #(.WIDTH(8), .BIT_CYCLES(1), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .data_in(a_data), .valid_in(a_valid), .dir(a_dir),
        .ready_out(a_ready), .sdata_out(a_sdata), .frame_out(a_frame), .done_out(a_done)
    );

    piso_serializer #(.WIDTH(8), .BIT_CYCLES(3), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .data_in(b_data), .valid_in(b_valid), .dir(b_dir),
        .ready_out(b_ready), .sdata_out(b_sdata), .frame_out(b_frame), .done_out(b_done)
    );

    piso_serializer #(.WIDTH(32), .BIT_CYCLES(1), .GAP_CYCLES(0)) dut_c (
        .clk(clk), .reset(reset), .data_in(c_data), .valid_in(c_valid), .dir(c_dir),
        .ready_out(c_ready), .sdata_out(c_sdata), .frame_out(c_frame), .done_out(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial-in shift register fed by config C, clocked only while framing.
    always @(posedge clk) begin
        if (c_frame) lb_q <= {lb_q[30:0], c_sdata};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outputs packed as {ready, frame, sdata, done}.
    task automatic test_reset();
        logic [3:0] obs;
        reset   = 1'b1;
        a_valid = 1'b1;          // valid together with reset must not be accepted
        a_data  = 8'hFF;
        step();
        step();
        obs = {a_ready, a_frame, a_sdata, a_done};
        checks++;
        if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL reset_a obs=%b exp=1000", obs);
        end
        obs = {c_ready, c_frame, c_sdata, c_done};
        checks++;
        if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL reset_c obs=%b exp=1000", obs);
        end
        reset   = 1'b0;
        a_valid = 1'b0;
        step();
        obs = {a_ready, a_frame, a_sdata, a_done};
        checks++;
        if (obs !== 4'b1000) begin
            failures++;
            $display("FAIL reset_wins obs=%b exp=1000", obs);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq = 8'b00011111;   // cycle 1 is seq[7]
        logic [3:0] obs, exp;
        a_data = 8'h1F; a_dir = 1'b0; a_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            a_valid = 1'b0;
            if (c <= 8)       exp = {1'b0, 1'b1, seq[8-c], 1'b0};
            else if (c == 9)  exp = 4'b0001;
            else if (c == 10) exp = 4'b0000;
            else              exp = 4'b1000;
            obs = {a_ready, a_frame, a_sdata, a_done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL msb_first cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq = 8'b11111000;
        logic [3:0] obs, exp;
        a_data = 8'h1F; a_dir = 1'b1; a_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            a_valid = 1'b0;
            a_dir   = 1'b0;
            if (c <= 8)       exp = {1'b0, 1'b1, seq[8-c], 1'b0};
            else if (c == 9)  exp = 4'b0001;
            else if (c == 10) exp = 4'b0000;
            else              exp = 4'b1000;
            obs = {a_ready, a_frame, a_sdata, a_done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL lsb_first cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_bit_cycles();
        logic [3:0] obs, exp;
        b_data = 8'h80; b_dir = 1'b0; b_valid = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            step();
            b_valid = 1'b0;
            if (c <= 3)       exp = 4'b0110;
            else if (c <= 24) exp = 4'b0100;
            else if (c == 25) exp = 4'b1001;
            else              exp = 4'b1000;
            obs = {b_ready, b_frame, b_sdata, b_done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL bit_cycles cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_busy();
        logic [7:0] seq = 8'b00111100;
        logic [3:0] obs, exp;
        int dones = 0;
        a_data = 8'h3C; a_dir = 1'b0; a_valid = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            a_valid = (c == 3);
            a_dir   = (c == 3);
            if (c == 3) a_data = 8'hFF;
            if (c <= 8)       exp = {1'b0, 1'b1, seq[8-c], 1'b0};
            else if (c == 9)  exp = 4'b0001;
            else if (c == 10) exp = 4'b0000;
            else              exp = 4'b1000;
            obs = {a_ready, a_frame, a_sdata, a_done};
            if (a_done) dones++;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL busy cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL busy_done_count got=%0d exp=1", dones);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] seq = 8'b10100101;
        logic [3:0] obs, exp;
        int dones = 0;
        a_data = 8'hFF; a_dir = 1'b0; a_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            a_valid = 1'b0;
            reset   = (c == 4);
            exp = (c <= 4) ? 4'b0110 : 4'b1000;
            obs = {a_ready, a_frame, a_sdata, a_done};
            if (a_done) dones++;
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
        checks++;
        if (dones !== 0) begin
            failures++;
            $display("FAIL reset_mid_done_count got=%0d exp=0", dones);
        end
        // A fresh word after the abort must go out intact.
        a_data = 8'hA5; a_valid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            a_valid = 1'b0;
            if (c <= 8)       exp = {1'b0, 1'b1, seq[8-c], 1'b0};
            else if (c == 9)  exp = 4'b0001;
            else if (c == 10) exp = 4'b0000;
            else              exp = 4'b1000;
            obs = {a_ready, a_frame, a_sdata, a_done};
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL after_reset cycle=%0d obs=%b exp=%b", c, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          done_cyc [2] = '{-1, -1};
        logic [31:0] done_val [2] = '{32'h0, 32'h0};
        int          ndone = 0;
        int          gaps  = 0;
        c_data = 32'hDEADBEEF; c_dir = 1'b0; c_valid = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            step();
            if (c == 1)  c_data  = 32'h12345678;  // waits for the done cycle
            if (c == 34) c_valid = 1'b0;
            if (c_done && ndone < 2) begin
                done_cyc[ndone] = c;
                done_val[ndone] = lb_q;
                ndone++;
            end
            if (c <= 65 && !c_frame) gaps++;
        end
        checks++;
        if (done_cyc[0] !== 33) begin
            failures++;
            $display("FAIL b2b_done1_cycle got=%0d exp=33", done_cyc[0]);
        end
        checks++;
        if (done_val[0] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL b2b_word1 got=%h exp=deadbeef", done_val[0]);
        end
        checks++;
        if (done_cyc[1] !== 66) begin
            failures++;
            $display("FAIL b2b_done2_cycle got=%0d exp=66", done_cyc[1]);
        end
        checks++;
        if (done_val[1] !== 32'h12345678) begin
            failures++;
            $display("FAIL b2b_word2 got=%h exp=12345678", done_val[1]);
        end
        checks++;
        if (gaps !== 1) begin
            failures++;
            $display("FAIL b2b_dead_cycles got=%0d exp=1", gaps);
        end
    endtask

    initial begin
        reset   = 1'b1;
        a_data  = '0; a_valid = 1'b0; a_dir = 1'b0;
        b_data  = '0; b_valid = 1'b0; b_dir = 1'b0;
        c_data  = '0; c_valid = 1'b0; c_dir = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_bit_cycles();
        test_busy();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
